bit_serializer: RTL and testbench



---
 rtl/seq_det_pkg.sv | 17 +
 rtl/bit_serializer.sv | 89 ++++++++
 tb/tb_bit_serializer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/seq_det_pkg.sv
// Definitions shared by the 1011 detector front end and its benches.
package seq_det_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   // Value presented to the detector when no payload bit is on the wire.
   localparam logic IDLE_BIT_DEFAULT = 1'b0;

   // A WIDTH of 2 still needs one counter bit.
   function automatic int cnt_width(input int w);
      return (w <= 2) ? 1 : $clog2(w);
   endfunction

endpackage

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end for the 1011 detector: valid/ready words in,
// one registered bit per clock out with valid and last-bit qualifiers.
module bit_serializer
   import seq_det_pkg::*;
#(
   parameter int   WIDTH     = 8,
   parameter bit   MSB_FIRST = 1'b1,
   parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic             x,
   output logic             x_valid,
   output logic             x_last,
   output logic             busy
);

   localparam int             CNT_W    = cnt_width(WIDTH);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   ser_state_e       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] sreg_q, sreg_d;
   logic             x_q, x_d;
   logic             x_valid_q, x_valid_d;
   logic             x_last_q, x_last_d;
   logic             accept;

   // Ready on the last bit as well, so consecutive words stream without a bubble.
   assign in_ready = (state_q == IDLE) || ((state_q == SHIFT) && (cnt_q == CNT_LAST));
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      sreg_d    = sreg_q;
      x_d       = x_q;
      x_valid_d = x_valid_q;
      x_last_d  = x_last_q;
      if (accept) begin
         state_d   = SHIFT;
         cnt_d     = '0;
         sreg_d    = in_data;
         x_d       = MSB_FIRST ? in_data[WIDTH-1] : in_data[0];
         x_valid_d = 1'b1;
         x_last_d  = 1'b0;
      end else if (state_q == SHIFT) begin
         if (cnt_q == CNT_LAST) begin
            state_d   = IDLE;
            x_d       = IDLE_BIT;
            x_valid_d = 1'b0;
            x_last_d  = 1'b0;
         end else begin
            // The bit on x is the head of sreg; the next one sits right behind it.
            cnt_d     = cnt_q + 1'b1;
            sreg_d    = MSB_FIRST ? (sreg_q << 1) : (sreg_q >> 1);
            x_d       = MSB_FIRST ? sreg_q[WIDTH-2] : sreg_q[1];
            x_last_d  = (cnt_d == CNT_LAST);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         sreg_q    <= '0;
         x_q       <= IDLE_BIT;
         x_valid_q <= 1'b0;
         x_last_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         sreg_q    <= sreg_d;
         x_q       <= x_d;
         x_valid_q <= x_valid_d;
         x_last_q  <= x_last_d;
      end
   end

   assign x       = x_q;
   assign x_valid = x_valid_q;
   assign x_last  = x_last_q;
   assign busy    = x_valid_q;

endmodule

// File: tb/tb_bit_serializer.sv
// Directed bench for bit_serializer: an MSB-first and an LSB-first instance.
module tb_bit_serializer;
   import seq_det_pkg::*;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic [7:0] in_data_m = 8'h00, in_data_l = 8'h00;
   logic       in_valid_m = 1'b0, in_valid_l = 1'b0;
   logic       in_ready_m, x_m, x_valid_m, x_last_m, busy_m;
   logic       in_ready_l, x_l, x_valid_l, x_last_l, busy_l;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) dut_m (
      .clk(clk), .reset(reset), .in_data(in_data_m), .in_valid(in_valid_m),
      .in_ready(in_ready_m), .x(x_m), .x_valid(x_valid_m), .x_last(x_last_m), .busy(busy_m)
   );

   bit_serializer #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) dut_l (
      .clk(clk), .reset(reset), .in_data(in_data_l), .in_valid(in_valid_l),
      .in_ready(in_ready_l), .x(x_l), .x_valid(x_valid_l), .x_last(x_last_l), .busy(busy_l)
   );

   // Observation vectors are {x, x_valid, x_last, in_ready, busy}.
   localparam logic [4:0] IDLE_V = 5'b0_0_0_1_0;

   task automatic test_reset();
      logic [4:0] obs;
      reset    = 1'b0;
      in_valid_m = 1'b1; in_data_m = 8'hFF;
      in_valid_l = 1'b1; in_data_l = 8'hFF;
      #1;
      obs = {x_m, x_valid_m, x_last_m, in_ready_m, busy_m};
      n_cmp++;
      if (obs !== IDLE_V) begin
         n_err++; $display("FAIL reset_t0 got=%b want=%b", obs, IDLE_V);
      end
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         obs = {x_m, x_valid_m, x_last_m, in_ready_m, busy_m};
         n_cmp++;
         if (obs !== IDLE_V) begin
            n_err++; $display("FAIL reset_hold_m c=%0d got=%b want=%b", c, obs, IDLE_V);
         end
         obs = {x_l, x_valid_l, x_last_l, in_ready_l, busy_l};
         n_cmp++;
         if (obs !== IDLE_V) begin
            n_err++; $display("FAIL reset_hold_l c=%0d got=%b want=%b", c, obs, IDLE_V);
         end
      end
      in_valid_m = 1'b0; in_valid_l = 1'b0;
      reset = 1'b1;
      @(negedge clk);
      obs = {x_m, x_valid_m, x_last_m, in_ready_m, busy_m};
      n_cmp++;
      if (obs !== IDLE_V) begin
         n_err++; $display("FAIL reset_release got=%b want=%b", obs, IDLE_V);
      end
   endtask

   task automatic test_msb_word();
      logic [7:0] bits = 8'hB6;
      logic [4:0] obs, exp;
      in_data_m = 8'hB6; in_valid_m = 1'b1;
      @(negedge clk);
      in_valid_m = 1'b0; in_data_m = 8'h5A;
      for (int i = 1; i <= 8; i++) begin
         exp = {bits[8-i], 1'b1, (i == 8), (i == 8), 1'b1};
         obs = {x_m, x_valid_m, x_last_m, in_ready_m, busy_m};
         n_cmp++;
         if (obs !== exp) begin
            n_err++; $display("FAIL msb_b6 cyc=%0d got=%b want=%b", i, obs, exp);
         end
         @(negedge clk);
      end
      obs = {x_m, x_valid_m, x_last_m, in_ready_m, busy_m};
      n_cmp++;
      if (obs !== IDLE_V) begin
         n_err++; $display("FAIL msb_b6_idle got=%b want=%b", obs, IDLE_V);
      end
   endtask

   task automatic test_back_to_back();
      logic [15:0] bits = 16'b1011_0000_0000_1011;
      logic [4:0]  obs, exp;
      in_data_m = 8'hB0; in_valid_m = 1'b1;
      @(negedge clk);
      for (int i = 1; i <= 16; i++) begin
         if (i == 1) in_data_m = 8'h0B;
         if (i == 9) in_valid_m = 1'b0;
         exp = {bits[16-i], 1'b1, (i == 8 || i == 16), (i == 8 || i == 16), 1'b1};
         obs = {x_m, x_valid_m, x_last_m, in_ready_m, busy_m};
         n_cmp++;
         if (obs !== exp) begin
            n_err++; $display("FAIL b2b cyc=%0d got=%b want=%b", i, obs, exp);
         end
         @(negedge clk);
      end
      obs = {x_m, x_valid_m, x_last_m, in_ready_m, busy_m};
      n_cmp++;
      if (obs !== IDLE_V) begin
         n_err++; $display("FAIL b2b_idle got=%b want=%b", obs, IDLE_V);
      end
   endtask

   task automatic test_lsb_first();
      logic [7:0] bits = 8'b0000_1101;   // expected x sequence 1,0,1,1,0,0,0,0 read from the right
      logic [4:0] obs, exp;
      in_data_l = 8'h0D; in_valid_l = 1'b1;
      @(negedge clk);
      in_valid_l = 1'b0; in_data_l = 8'hFF;
      for (int i = 1; i <= 8; i++) begin
         exp = {bits[i-1], 1'b1, (i == 8), (i == 8), 1'b1};
         obs = {x_l, x_valid_l, x_last_l, in_ready_l, busy_l};
         n_cmp++;
         if (obs !== exp) begin
            n_err++; $display("FAIL lsb_0d cyc=%0d got=%b want=%b", i, obs, exp);
         end
         @(negedge clk);
      end
      obs = {x_l, x_valid_l, x_last_l, in_ready_l, busy_l};
      n_cmp++;
      if (obs !== IDLE_V) begin
         n_err++; $display("FAIL lsb_0d_idle got=%b want=%b", obs, IDLE_V);
      end
   endtask

   task automatic test_reset_mid_word();
      logic [4:0] obs, exp;
      in_data_m = 8'hFF; in_valid_m = 1'b1;
      @(negedge clk);
      in_valid_m = 1'b0;
      for (int i = 1; i <= 3; i++) begin
         exp = 5'b1_1_0_0_1;
         obs = {x_m, x_valid_m, x_last_m, in_ready_m, busy_m};
         n_cmp++;
         if (obs !== exp) begin
            n_err++; $display("FAIL rstmid_ff cyc=%0d got=%b want=%b", i, obs, exp);
         end
         if (i < 3) @(negedge clk);
      end
      #2 reset = 1'b0;
      #1;
      obs = {x_m, x_valid_m, x_last_m, in_ready_m, busy_m};
      n_cmp++;
      if (obs !== IDLE_V) begin
         n_err++; $display("FAIL rstmid_async got=%b want=%b", obs, IDLE_V);
      end
      @(negedge clk);
      reset = 1'b1;
      in_data_m = 8'h80; in_valid_m = 1'b1;
      @(negedge clk);
      in_valid_m = 1'b0;
      for (int i = 1; i <= 8; i++) begin
         exp = {(i == 1), 1'b1, (i == 8), (i == 8), 1'b1};
         obs = {x_m, x_valid_m, x_last_m, in_ready_m, busy_m};
         n_cmp++;
         if (obs !== exp) begin
            n_err++; $display("FAIL rstmid_80 cyc=%0d got=%b want=%b", i, obs, exp);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_ignore_and_late_accept();
      logic [15:0] bits = 16'hB600;
      logic [4:0]  obs, exp;
      in_data_m = 8'hB6; in_valid_m = 1'b1;
      @(negedge clk);
      in_valid_m = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         // cyc 4 is cnt=3 (must be ignored); cyc 8 is cnt=7 (must be taken).
         if (i == 4 || i == 8) begin in_data_m = 8'h00; in_valid_m = 1'b1; end
         if (i == 5 || i == 9) begin in_data_m = 8'hFF; in_valid_m = 1'b0; end
         exp = {bits[16-i], 1'b1, (i == 8 || i == 16), (i == 8 || i == 16), 1'b1};
         obs = {x_m, x_valid_m, x_last_m, in_ready_m, busy_m};
         n_cmp++;
         if (obs !== exp) begin
            n_err++; $display("FAIL ignore_b6_00 cyc=%0d got=%b want=%b", i, obs, exp);
         end
         @(negedge clk);
      end
      obs = {x_m, x_valid_m, x_last_m, in_ready_m, busy_m};
      n_cmp++;
      if (obs !== IDLE_V) begin
         n_err++; $display("FAIL ignore_idle got=%b want=%b", obs, IDLE_V);
      end
   endtask

   initial begin
      test_reset();
      test_msb_word();
      test_back_to_back();
      test_lsb_first();
      test_reset_mid_word();
      test_ignore_and_late_accept();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
